sram_dp_be: RTL and testbench

Parametrised dual-port synchronous SRAM simulation model with per-byte write enables, configurable read latency and a defined cross-port collision policy. It is the successor to the single-port behavioural SRAM and serves as instruction/data backing store in the simulation top. Ports A and B are fully independent read/write ports with a per-port read-valid pipeline. Memory contents are never reset. Only the read pipeline is cleared by reset.

---
 rtl/sram_dp_be.sv | 104 ++++++++++
 tb/tb_sram_dp_be.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_be.sv
// Dual-port synchronous SRAM model with per-byte write enables, a configurable read
// latency pipeline per port and a fixed cross-port collision policy (A wins write/write).
module sram_dp_be #(
    parameter int AW       = 15,
    parameter int DW       = 32,
    parameter int DEPTH    = 2**AW,
    parameter int READ_LAT = 1,
    parameter int RDW_NEW  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_en,
    input  logic            a_wen,
    input  logic [DW/8-1:0] a_be,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_wdata,
    output logic [DW-1:0]   a_rdata,
    output logic            a_rvalid,
    input  logic            b_en,
    input  logic            b_wen,
    input  logic [DW/8-1:0] b_be,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_wdata,
    output logic [DW-1:0]   b_rdata,
    output logic            b_rvalid
);

    localparam int NB = DW / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];

    // Index 0 is port A, index 1 is port B, so both ports share one description.
    logic [AW-1:0]   addr  [2];
    logic [IW-1:0]   idx   [2];
    logic [NB-1:0]   be    [2];
    logic [DW-1:0]   wdata [2];
    logic [1:0]      inr;
    logic [1:0]      wr;
    logic [1:0]      rd;
    logic [DW-1:0]   rword [2];
    logic [READ_LAT-1:0] vpipe [2];
    logic [DW-1:0]   dpipe [2][READ_LAT];

    assign addr[0]  = a_addr;
    assign addr[1]  = b_addr;
    assign be[0]    = a_be;
    assign be[1]    = b_be;
    assign wdata[0] = a_wdata;
    assign wdata[1] = b_wdata;
    assign idx[0]   = a_addr[IW-1:0];
    assign idx[1]   = b_addr[IW-1:0];
    assign inr[0]   = {1'b0, a_addr} < DEPTH_L;
    assign inr[1]   = {1'b0, b_addr} < DEPTH_L;

    // Accesses presented while reset is high are ignored entirely.
    assign wr[0] = a_en & a_wen & inr[0] & ~rst;
    assign wr[1] = b_en & b_wen & inr[1] & ~rst;
    assign rd[0] = a_en & ~a_wen & ~rst;
    assign rd[1] = b_en & ~b_wen & ~rst;

    // Port B is written first so port A's later assignment wins on shared bytes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr[1] && be[1][i]) mem[idx[1]][8*i +: 8] <= wdata[1][8*i +: 8];
            if (wr[0] && be[0][i]) mem[idx[0]][8*i +: 8] <= wdata[0][8*i +: 8];
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rword[p] = inr[p] ? mem[idx[p]] : '0;
            if (RDW_NEW != 0 && wr[1-p] && addr[1-p] == addr[p]) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[1-p][i]) rword[p][8*i +: 8] = wdata[1-p][8*i +: 8];
                end
            end
        end
    end

    // Data stages only advance behind a valid bit, so rdata holds between pulses.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                vpipe[p] <= '0;
                for (int k = 0; k < READ_LAT; k++) dpipe[p][k] <= '0;
            end else begin
                vpipe[p][0] <= rd[p];
                if (rd[p]) dpipe[p][0] <= rword[p];
                for (int k = 1; k < READ_LAT; k++) begin
                    vpipe[p][k] <= vpipe[p][k-1];
                    if (vpipe[p][k-1]) dpipe[p][k] <= dpipe[p][k-1];
                end
            end
        end
    end

    assign a_rvalid = vpipe[0][READ_LAT-1];
    assign b_rvalid = vpipe[1][READ_LAT-1];
    assign a_rdata  = dpipe[0][READ_LAT-1];
    assign b_rdata  = dpipe[1][READ_LAT-1];

endmodule

// File: tb/tb_sram_dp_be.sv
// Scoreboard bench for sram_dp_be: three instances (latency 1/3/4, RDW old/new, short
// depth) share one stimulus stream; a negedge monitor pops expected reads as they emerge.
module tb_sram_dp_be;

    localparam int LAT [3] = '{1, 3, 4};
    localparam int RDW [3] = '{0, 1, 0};
    localparam int DEP [3] = '{100, 256, 256};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_wen = 1'b0, b_en = 1'b0, b_wen = 1'b0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic [7:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic [31:0] rdata [3][2];
    logic        rvalid [3][2];

    logic [31:0] mm [3][256];
    logic [31:0] expData [3][2][$];
    int          expDue [3][2][$];
    logic [31:0] lastExp [3][2];
    logic [31:0] lastGot [3][2];
    int          pulseCnt [3][2];
    int          snap [3];
    int          cyc = 0;
    int          nTotal = 0;
    int          nBad = 0;
    logic        monOn = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_dp_be #(.AW(8), .DW(32), .DEPTH(100), .READ_LAT(1), .RDW_NEW(0)) u0 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rdata[0][0]), .a_rvalid(rvalid[0][0]),
        .b_en(b_en), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(rdata[0][1]), .b_rvalid(rvalid[0][1]));

    sram_dp_be #(.AW(8), .DW(32), .DEPTH(256), .READ_LAT(3), .RDW_NEW(1)) u1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rdata[1][0]), .a_rvalid(rvalid[1][0]),
        .b_en(b_en), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(rdata[1][1]), .b_rvalid(rvalid[1][1]));

    sram_dp_be #(.AW(8), .DW(32), .DEPTH(256), .READ_LAT(4), .RDW_NEW(0)) u2 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rdata[2][0]), .a_rvalid(rvalid[2][0]),
        .b_en(b_en), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(rdata[2][1]), .b_rvalid(rvalid[2][1]));

    function automatic logic [31:0] modelRead(input int i, input logic [7:0] raddr, input logic ow,
                                              input logic [3:0] obe, input logic [7:0] oaddr,
                                              input logic [31:0] owd);
        logic [31:0] w;
        if (int'(raddr) >= DEP[i]) return 32'h0;
        w = mm[i][raddr];
        if (RDW[i] != 0 && ow && oaddr == raddr) begin
            for (int b = 0; b < 4; b++) if (obe[b]) w[8*b +: 8] = owd[8*b +: 8];
        end
        return w;
    endfunction

    // Drives one cycle, predicts read results before the edge and commits writes after it.
    task automatic applyStimulus(input logic ae, input logic aw, input logic [3:0] abe,
                                 input logic [7:0] aad, input logic [31:0] awd,
                                 input logic bEn, input logic bw, input logic [3:0] bbe,
                                 input logic [7:0] bad, input logic [31:0] bwd, input logic r);
        logic [31:0] ra [3];
        logic [31:0] rb [3];
        a_en = ae; a_wen = aw; a_be = abe; a_addr = aad; a_wdata = awd;
        b_en = bEn; b_wen = bw; b_be = bbe; b_addr = bad; b_wdata = bwd;
        rst = r;
        for (int i = 0; i < 3; i++) begin
            ra[i] = modelRead(i, aad, bEn && bw, bbe, bad, bwd);
            rb[i] = modelRead(i, bad, ae && aw, abe, aad, awd);
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                for (int p = 0; p < 2; p++) begin
                    while (expDue[i][p].size() > 0 && expDue[i][p][$] >= cyc) begin
                        void'(expDue[i][p].pop_back());
                        void'(expData[i][p].pop_back());
                    end
                    lastExp[i][p] = 32'h0;
                end
            end else begin
                if (ae && !aw) begin
                    expData[i][0].push_back(ra[i]);
                    expDue[i][0].push_back(cyc + LAT[i] - 1);
                end
                if (bEn && !bw) begin
                    expData[i][1].push_back(rb[i]);
                    expDue[i][1].push_back(cyc + LAT[i] - 1);
                end
                for (int b = 0; b < 4; b++) begin
                    if (bEn && bw && bbe[b] && int'(bad) < DEP[i]) mm[i][bad][8*b +: 8] = bwd[8*b +: 8];
                    if (ae && aw && abe[b] && int'(aad) < DEP[i]) mm[i][aad][8*b +: 8] = awd[8*b +: 8];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 4'h0, 8'h0, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
    endtask

    task automatic wrA(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] m);
        applyStimulus(1, 1, m, ad, d, 0, 0, 4'h0, 8'h0, 32'h0, 0);
    endtask

    task automatic wrB(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] m);
        applyStimulus(0, 0, 4'h0, 8'h0, 32'h0, 1, 1, m, ad, d, 0);
    endtask

    task automatic rdA(input logic [7:0] ad);
        applyStimulus(1, 0, 4'h0, ad, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
    endtask

    task automatic rdB(input logic [7:0] ad);
        applyStimulus(0, 0, 4'h0, 8'h0, 32'h0, 1, 0, 4'h0, ad, 32'h0, 0);
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 2; p++) begin
                    nTotal++;
                    if (rvalid[i][p] === 1'b1) begin
                        pulseCnt[i][p]++;
                        lastGot[i][p] = rdata[i][p];
                        if (expDue[i][p].size() == 0) begin
                            nBad++;
                            $display("[TB] FAIL spurious_rvalid inst=%0d port=%0d cycle=%0d rdata=%h want no pulse",
                                     i, p, cyc, rdata[i][p]);
                        end else begin
                            automatic int due = expDue[i][p].pop_front();
                            automatic logic [31:0] d = expData[i][p].pop_front();
                            lastExp[i][p] = d;
                            if (rdata[i][p] !== d || due != cyc) begin
                                nBad++;
                                $display("[TB] FAIL read_data inst=%0d port=%0d got=%h@%0d want=%h@%0d",
                                         i, p, rdata[i][p], cyc, d, due);
                            end
                        end
                    end else if (rvalid[i][p] !== 1'b0) begin
                        nBad++;
                        $display("[TB] FAIL rvalid_x inst=%0d port=%0d got=%b want=0/1", i, p, rvalid[i][p]);
                    end else if (expDue[i][p].size() > 0 && expDue[i][p][0] <= cyc) begin
                        nBad++;
                        $display("[TB] FAIL missing_rvalid inst=%0d port=%0d cycle=%0d got=0 want=1 due=%0d",
                                 i, p, cyc, expDue[i][p][0]);
                        void'(expDue[i][p].pop_front());
                        void'(expData[i][p].pop_front());
                    end else if (rdata[i][p] !== lastExp[i][p]) begin
                        nBad++;
                        $display("[TB] FAIL rdata_hold inst=%0d port=%0d got=%h want=%h",
                                 i, p, rdata[i][p], lastExp[i][p]);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        applyStimulus(0, 0, 4'h0, 8'h0, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0, 1);
        applyStimulus(1, 1, 4'hF, 8'h10, 32'h12345678, 1, 0, 4'h0, 8'h10, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                nTotal++;
                if (rdata[i][p] !== 32'h0) begin
                    nBad++;
                    $display("[TB] FAIL reset_rdata inst=%0d port=%0d got=%h want=0", i, p, rdata[i][p]);
                end
                nTotal++;
                if (rvalid[i][p] !== 1'b0) begin
                    nBad++;
                    $display("[TB] FAIL reset_rvalid inst=%0d port=%0d got=%b want=0", i, p, rvalid[i][p]);
                end
            end
        end
        monOn = 1'b1;
        idle(5);
    endtask

    task automatic test_byte_enable();
        wrA(8'h10, 32'h0, 4'hF);
        wrA(8'h10, 32'hDEADBEEF, 4'b0101);
        rdA(8'h10);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            nTotal++;
            if (lastGot[i][0] !== 32'h00AD00EF) begin
                nBad++;
                $display("[TB] FAIL byte_enable inst=%0d got=%h want=00ad00ef", i, lastGot[i][0]);
            end
        end
        wrA(8'h10, 32'hFFFFFFFF, 4'b0000);
        rdB(8'h10);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            nTotal++;
            if (lastGot[i][1] !== 32'h00AD00EF) begin
                nBad++;
                $display("[TB] FAIL be_zero_noop inst=%0d got=%h want=00ad00ef", i, lastGot[i][1]);
            end
        end
    endtask

    task automatic test_write_collision();
        applyStimulus(1, 1, 4'b0011, 8'h20, 32'h11111111, 1, 1, 4'b1111, 8'h20, 32'h22222222, 0);
        rdB(8'h20);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            nTotal++;
            if (lastGot[i][1] !== 32'h22221111) begin
                nBad++;
                $display("[TB] FAIL ww_collision inst=%0d got=%h want=22221111", i, lastGot[i][1]);
            end
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] want;
        wrA(8'h30, 32'hAAAAAAAA, 4'hF);
        applyStimulus(1, 1, 4'hF, 8'h30, 32'h55555555, 1, 0, 4'h0, 8'h30, 32'h0, 0);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            want = (RDW[i] != 0) ? 32'h55555555 : 32'hAAAAAAAA;
            nTotal++;
            if (lastGot[i][1] !== want) begin
                nBad++;
                $display("[TB] FAIL rdw_b_reads inst=%0d got=%h want=%h", i, lastGot[i][1], want);
            end
        end
        applyStimulus(1, 0, 4'h0, 8'h30, 32'h0, 1, 1, 4'b0011, 8'h30, 32'h66666666, 0);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            want = (RDW[i] != 0) ? 32'h55556666 : 32'h55555555;
            nTotal++;
            if (lastGot[i][0] !== want) begin
                nBad++;
                $display("[TB] FAIL rdw_a_reads inst=%0d got=%h want=%h", i, lastGot[i][0], want);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) wrB(8'(k), 32'hC0DE0000 + 32'(k), 4'hF);
        for (int i = 0; i < 3; i++) snap[i] = pulseCnt[i][1];
        for (int k = 0; k < 8; k++)
            applyStimulus(1, 0, 4'h0, 8'(7 - k), 32'h0, 1, 0, 4'h0, 8'(k), 32'h0, 0);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            nTotal++;
            if (pulseCnt[i][1] - snap[i] != 8) begin
                nBad++;
                $display("[TB] FAIL b2b_pulses inst=%0d got=%0d want=8", i, pulseCnt[i][1] - snap[i]);
            end
            nTotal++;
            if (lastGot[i][1] !== 32'hC0DE0007) begin
                nBad++;
                $display("[TB] FAIL b2b_last inst=%0d got=%h want=c0de0007", i, lastGot[i][1]);
            end
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) snap[i] = pulseCnt[i][0];
        rdA(8'h10);
        applyStimulus(0, 0, 4'h0, 8'h0, 32'h0, 1, 1, 4'hF, 8'h30, 32'h0, 1);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            nTotal++;
            if (pulseCnt[i][0] - snap[i] != ((LAT[i] == 1) ? 1 : 0)) begin
                nBad++;
                $display("[TB] FAIL flush_pulses inst=%0d got=%0d want=%0d",
                         i, pulseCnt[i][0] - snap[i], (LAT[i] == 1) ? 1 : 0);
            end
        end
        applyStimulus(1, 0, 4'h0, 8'h20, 32'h0, 1, 0, 4'h0, 8'h30, 32'h0, 0);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            nTotal++;
            if (lastGot[i][0] !== 32'h22221111) begin
                nBad++;
                $display("[TB] FAIL mem_survives inst=%0d got=%h want=22221111", i, lastGot[i][0]);
            end
            nTotal++;
            if (lastGot[i][1] !== 32'h55556666) begin
                nBad++;
                $display("[TB] FAIL reset_write_ignored inst=%0d got=%h want=55556666", i, lastGot[i][1]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] want;
        wrB(8'd120, 32'hCAFEF00D, 4'hF);
        wrA(8'd99, 32'h0099ABCD, 4'hF);
        wrA(8'd72, 32'h72727272, 4'hF);
        wrB(8'd200, 32'hDEAD0200, 4'hF);
        rdB(8'd120);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            want = (DEP[i] <= 120) ? 32'h0 : 32'hCAFEF00D;
            nTotal++;
            if (lastGot[i][1] !== want) begin
                nBad++;
                $display("[TB] FAIL oor_read inst=%0d got=%h want=%h", i, lastGot[i][1], want);
            end
        end
        applyStimulus(1, 0, 4'h0, 8'd99, 32'h0, 1, 0, 4'h0, 8'd200, 32'h0, 0);
        rdA(8'd72);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            want = (DEP[i] <= 200) ? 32'h0 : 32'hDEAD0200;
            nTotal++;
            if (lastGot[i][1] !== want) begin
                nBad++;
                $display("[TB] FAIL oor_read_200 inst=%0d got=%h want=%h", i, lastGot[i][1], want);
            end
            nTotal++;
            if (lastGot[i][0] !== 32'h72727272) begin
                nBad++;
                $display("[TB] FAIL oor_no_alias inst=%0d got=%h want=72727272", i, lastGot[i][0]);
            end
        end
        rdA(8'd99);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            nTotal++;
            if (lastGot[i][0] !== 32'h0099ABCD) begin
                nBad++;
                $display("[TB] FAIL last_addr inst=%0d got=%h want=0099abcd", i, lastGot[i][0]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                lastExp[i][p] = 32'h0;
                lastGot[i][p] = 32'h0;
                pulseCnt[i][p] = 0;
            end
        end
        test_reset();
        test_byte_enable();
        test_write_collision();
        test_read_during_write();
        test_back_to_back();
        test_reset_flush();
        test_out_of_range();
        idle(2);
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
